// File: rtl/aes_pkg.sv
// Shared AES definitions: sequencer FSM states, byte count and the index
// widths used to split a byte number into row and column.
package aes_pkg;

  localparam int NUM_BYTES = 16;
  localparam int ROW_W     = 2;
  localparam int COL_W     = 2;
  localparam int CNT_W     = ROW_W + COL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sub_shift_seq_sub_byte.sv
// SubByte: one AES S-box lookup per cycle with a registered output.
// enc_en=1 gives the forward S-box, enc_en=0 the inverse S-box. Both are
// computed as a GF(2^8) inverse combined with the AES affine transform.
module sub_byte (
  input  logic       clk,
  input  logic       enc_en,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // Registered lookup: result for the byte presented now appears next cycle.
  always_ff @(posedge clk) begin
    out_byte <= enc_en ? affine(gf_inv(in_byte)) : gf_inv(inv_affine(in_byte));
  end

endmodule

// File: rtl/sub_shift_seq.sv
// sub_shift_seq: byte-serial AES SubBytes (+ShiftRows) on a 128-bit state.
// One byte is sent through a single shared S-box per cycle; the S-box result
// is written into the result register one cycle later, 17 cycles per state.
// Optional feature macro SUB_SHIFT_ROWS_EN: when defined, the writeback
// position applies ShiftRows (encrypt) / InvShiftRows (decrypt); when
// undefined each byte is written back in place.
module sub_shift_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_enc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [127:0]       src_reg;
  logic               enc_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               busy_reg;

  logic [7:0]         src_bytes [NUM_BYTES];
  logic [7:0]         res_bytes_reg [NUM_BYTES];
  logic [7:0]         sbox_in;
  logic [7:0]         sbox_out;

  logic               wb_en;
  logic [CNT_W-1:0]   wb_idx;
  logic [ROW_W-1:0]   wb_row;
  logic [COL_W-1:0]   wb_col;
  logic [CNT_W-1:0]   wb_pos;

  // Byte views of the latched input and of the result register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
      assign src_bytes[gi]                = src_reg[127-8*gi -: 8];
      assign out_state[127-8*gi -: 8]     = res_bytes_reg[gi];
    end
  endgenerate

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

  // Byte issued to the S-box this cycle.
  always_comb sbox_in = src_bytes[cnt_reg];

  sub_byte u_sub_byte (
    .clk      (clk),
    .enc_en   (enc_reg),
    .in_byte  (sbox_in),
    .out_byte (sbox_out)
  );

  // The S-box output now belongs to the byte issued last cycle (cnt-1).
  // In DRAIN cnt has wrapped to 0, so cnt-1 is byte 15.
  always_comb begin
    wb_en  = ((state_reg == RUN) && (cnt_reg != '0)) || (state_reg == DRAIN);
    wb_idx = cnt_reg - 1'b1;
    wb_row = wb_idx[ROW_W-1:0];
    wb_col = wb_idx[CNT_W-1:ROW_W];
`ifdef SUB_SHIFT_ROWS_EN
    if (enc_reg) wb_col = wb_idx[CNT_W-1:ROW_W] - wb_row;
    else         wb_col = wb_idx[CNT_W-1:ROW_W] + wb_row;
`endif
    wb_pos = {wb_col, wb_row};
  end

  // Sequencer: accept, 16 issue cycles, one drain cycle, then hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      src_reg       <= '0;
      enc_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            src_reg      <= in_state;
            enc_reg      <= in_enc;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(NUM_BYTES - 1)) state_reg <= DRAIN;
        end
        DRAIN: begin
          state_reg     <= DONE;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Result register: scattered writeback of each S-box result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BYTES; i++) res_bytes_reg[i] <= '0;
    end else if (wb_en) begin
      res_bytes_reg[wb_pos] <= sbox_out;
    end
  end

endmodule

// File: doc/sub_shift_seq.md
SUB_SHIFT_SEQ -- requirements
Module: sub_shift_seq

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port `in_valid`, input, 1 bit: the upstream 128-bit state is valid.
REQ-005 The block SHALL have port `in_ready`, output, 1 bit: the block can accept a state.
REQ-006 The block SHALL have port `in_state`, input, 128 bits: AES state; byte i = `in_state[127-8i -: 8]`, row i%4, column i/4.
REQ-007 The block SHALL have port `in_enc`, input, 1 bit: 1 = encrypt (S-box and ShiftRows), 0 = decrypt (inverse S-box and InvShiftRows).
REQ-008 The block SHALL have port `out_valid`, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port `out_ready`, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port `out_state`, output, 128 bits: result state, same byte order as `in_state`.
REQ-011 The block SHALL have port `busy`, output, 1 bit: the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, RUN, DRAIN, DONE.
REQ-013 In IDLE: `in_ready`=1; on `in_valid & in_ready` the block SHALL latch `in_state` and `in_enc`, clear the byte counter, and go to RUN.
REQ-014 In RUN: each cycle the block SHALL present latched byte[cnt] to a SubByte instance with `enc_en` = latched `in_enc`, then increment cnt (4 bits); after cnt=15 it SHALL go to DRAIN.
REQ-015 SubByte output is registered with 1-cycle latency; the block SHALL write the S-box output for byte k into the result register one cycle after byte k is issued.
REQ-016 Writeback position:
- Input byte (r,c) SHALL land at (r,(c-r) mod 4) when encrypting.
- Input byte (r,c) SHALL land at (r,(c+r) mod 4) when decrypting.
- Column arithmetic SHALL be 2-bit wrap-around.
REQ-017 In DRAIN the block SHALL write byte 15 and go to DONE.
REQ-018 `out_valid` SHALL be asserted exactly 17 cycles after the accepting edge.
REQ-019 In DONE: `out_valid`=1 and `out_state` SHALL be stable until `out_valid & out_ready`, after which the FSM returns to IDLE.
REQ-020 `in_ready` SHALL be 0 in RUN, DRAIN and DONE; `in_valid` in those states SHALL be ignored; no same-cycle accept on DONE exit.
REQ-021 Holding `out_ready`=1 before DONE SHALL have no effect; holding it low SHALL stall indefinitely without corrupting the result.
REQ-022 A change of `in_enc` after accept SHALL NOT affect the operation in progress.

Reset
REQ-023 With `rst`=1 at a clock edge, the block SHALL go to IDLE with cnt=0, result register=0, `out_valid`=0, `busy`=0, `in_ready`=1 after that edge.
REQ-024 Reset in any state SHALL discard the operation in progress; no partial result is ever presented.

Configuration
REQ-025 Macro `SUB_SHIFT_ROWS_EN`:
- Defined: writeback SHALL apply REQ-016.
- Undefined: byte k SHALL write to position k (SubBytes/InvSubBytes only); latency and handshake SHALL be unchanged.

Structure
REQ-026 A shared package `aes_pkg` SHALL hold the FSM state enum, the constant NUM_BYTES=16, and the row/column index width constants.
REQ-027 The block SHALL contain exactly one sub-module: the existing SubByte S-box, instantiated once and driven by `clk`.

Verification
REQ-028 Encrypt, macro defined: input 0x193de3bea0f4e22b9ac68d2ae9f84808 -> output 0xd4bf5d30e0b452aeb84111f11e2798e5, `out_valid` 17 cycles after accept.
REQ-029 Decrypt, macro defined: input 0xd4bf5d30e0b452aeb84111f11e2798e5 -> output 0x193de3bea0f4e22b9ac68d2ae9f84808.
REQ-030 Encrypt of all-zero input -> output 0x63636363636363636363636363636363, in both macro configurations.
REQ-031 Backpressure: `out_ready`=0 for 10 cycles in DONE -> `out_state` stable and `in_ready`=0 throughout; first `out_ready`=1 -> IDLE the next cycle.
REQ-032 Assert `rst` at RUN cnt=7, then accept a new input -> `out_valid`=0 through reset; the new result is correct with no residue from the aborted state.
REQ-033 Macro undefined, encrypt input 0x193de3bea0f4e22b9ac68d2ae9f84808 -> output 0xd42711aee0bf98f1b8b45de51e415230.
